// File: rtl/clk_sel_ctrl.sv
// Glitch-free clock source select controller: heartbeat liveness, gate-off/settle switch sequencing, sticky fault.
// Optional autonomous failover to the live source when CLK_SEL_AUTO_FAILOVER_EN is defined.
module clk_sel_ctrl #(
  parameter int GATE_CYC   = 4,
  parameter int SETTLE_CYC = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_sel,
  input  logic       hb_diff,
  input  logic       hb_se,
  input  logic       fault_clr,
  output logic       sel,
  output logic       gate_en,
  output logic       busy,
  output logic       diff_alive,
  output logic       se_alive,
  output logic       fault,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    STARTUP  = 2'd0,
    RUN      = 2'd1,
    GATE_OFF = 2'd2,
    SETTLE   = 2'd3
  } state_t;

  localparam int              SW          = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0]   TO          = SW'(TIMEOUT);
  localparam logic [7:0]      GATE_LAST   = 8'(GATE_CYC - 1);
  localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE_CYC - 1);

  logic          hb_diff_q, hb_se_q;
  logic [SW-1:0] diff_cnt, se_cnt;

  // Silence counters start saturated so neither source is trusted until it toggles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_diff_q <= 1'b0;
      hb_se_q   <= 1'b0;
      diff_cnt  <= TO;
      se_cnt    <= TO;
    end else begin
      hb_diff_q <= hb_diff;
      hb_se_q   <= hb_se;
      if (hb_diff != hb_diff_q)  diff_cnt <= '0;
      else if (diff_cnt != TO)   diff_cnt <= diff_cnt + SW'(1);
      if (hb_se != hb_se_q)      se_cnt   <= '0;
      else if (se_cnt != TO)     se_cnt   <= se_cnt + SW'(1);
    end
  end

  assign diff_alive = (diff_cnt < TO);
  assign se_alive   = (se_cnt < TO);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       sel_d, gate_d, fault_set;
  logic       cur_alive, tgt_alive;

  assign cur_alive = sel ? diff_alive : se_alive;
  assign tgt_alive = sel ? se_alive   : diff_alive;

`ifdef CLK_SEL_AUTO_FAILOVER_EN
  // Set by a failover; blocks request-driven switching until req_sel agrees with sel.
  logic lock_q, lock_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel;
    gate_d    = gate_en;
    fault_set = 1'b0;
`ifdef CLK_SEL_AUTO_FAILOVER_EN
    lock_d    = lock_q;
`endif
    case (state_q)
      STARTUP: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
          gate_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RUN: begin
        if (!cur_alive)                  fault_set = 1'b1;
        if (req_sel != sel && !tgt_alive) fault_set = 1'b1;
`ifdef CLK_SEL_AUTO_FAILOVER_EN
        if (!cur_alive && tgt_alive) begin
          state_d = GATE_OFF;
          cnt_d   = '0;
          gate_d  = 1'b0;
          lock_d  = 1'b1;
        end else if (req_sel == sel) begin
          lock_d = 1'b0;
        end else if (!lock_q && tgt_alive) begin
          state_d = GATE_OFF;
          cnt_d   = '0;
          gate_d  = 1'b0;
        end
`else
        if (req_sel != sel && tgt_alive) begin
          state_d = GATE_OFF;
          cnt_d   = '0;
          gate_d  = 1'b0;
        end
`endif
      end
      GATE_OFF: begin
        // The mux only moves here, with the gate already closed.
        if (cnt_q == GATE_LAST) begin
          state_d = SETTLE;
          cnt_d   = '0;
          sel_d   = ~sel;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
          gate_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = STARTUP;
        cnt_d   = '0;
        gate_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STARTUP;
      cnt_q   <= '0;
      sel     <= 1'b0;
      gate_en <= 1'b0;
      fault   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel     <= sel_d;
      gate_en <= gate_d;
      if (fault_set)      fault <= 1'b1;
      else if (fault_clr) fault <= 1'b0;
    end
  end

`ifdef CLK_SEL_AUTO_FAILOVER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_q <= 1'b0;
    else        lock_q <= lock_d;
  end
`endif

  assign busy      = (state_q != RUN);
  assign state_dbg = state_q;

endmodule
